// File: rtl/clint_timer_unit_pkg.sv
// -----------------------------------------------------------------------------
// clint_timer_unit_pkg
// Purpose : shared constants, FSM state type and the byte-merge helper used by
//           the CLINT timer unit and its mtime counter sub-module.
// Contents: register offsets (relative to BASE_ADDR), FSM encodings,
//           merge_bytes() for byte-enabled register writes.
// Optional feature macro: CLINT_MSIP_EN (msip register; see clint_timer_unit).
// -----------------------------------------------------------------------------
package clint_timer_unit_pkg;

    // Register offsets inside the CLINT region
    localparam logic [63:0] CLINT_MSIP_OFS     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFS = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME_OFS    = 64'h0000_0000_0000_BFF8;

    // Bus FSM: one request outstanding, response held until consumed
    typedef enum logic [0:0] {
        CLINT_FSM_IDLE = 1'b0,
        CLINT_FSM_RESP = 1'b1
    } clint_state_e;

    // Byte-enabled merge: byte i comes from wdata when wstrb[i] is set
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] wdata,
        input logic [7:0]  wstrb
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_unit_mtime_cnt.sv
// -----------------------------------------------------------------------------
// clint_mtime_cnt
// Purpose : prescaler plus 64-bit free-running mtime register with a bus
//           write port. A bus write in the same cycle as a tick wins.
// Ports   : clk        clock
//           rst        synchronous active-low reset
//           i_wr_en    load i_wr_data into mtime this edge
//           i_wr_data  value to load (already byte-merged by the caller)
//           o_mtime    current mtime
// -----------------------------------------------------------------------------
module clint_mtime_cnt #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [63:0] i_wr_data,
    output logic [63:0] o_mtime
);

    // Counter is at least one bit wide so TICK_DIV=1 still elaborates
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [63:0]      r_mtime;
    logic             w_tick;

    assign w_tick  = (r_div_cnt == DIV_LAST);
    assign o_mtime = r_mtime;

    // Prescaler: counts 0..TICK_DIV-1 and restarts after each tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // mtime: bus write has priority over the tick increment; wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mtime <= 64'd0;
        end else if (i_wr_en) begin
            r_mtime <= i_wr_data;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_mtime <= r_mtime;
        end
    end

endmodule

// File: rtl/clint_timer_unit.sv
// -----------------------------------------------------------------------------
// clint_timer_unit
// Purpose : core-local interruptor. Holds mtime/mtimecmp (and optionally msip)
//           behind a one-outstanding valid/ready register port and drives the
//           timer interrupt to the CSR unit.
// Ports   : clk, rst (sync, active-low)
//           req_valid/req_ready, req_addr, req_wen, req_wdata, req_wstrb
//           rsp_valid/rsp_ready, rsp_rdata, rsp_err
//           clint_mtip  registered (mtime >= mtimecmp)
//           clint_msip  msip register (only when CLINT_MSIP_EN is defined)
// Macro   : CLINT_MSIP_EN enables the msip register at BASE_ADDR+0x0; without
//           it that address is unmapped and clint_msip does not exist.
// -----------------------------------------------------------------------------
module clint_timer_unit
    import clint_timer_unit_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clint_mtip
`ifdef CLINT_MSIP_EN
    ,
    output logic        clint_msip
`endif
);

    clint_state_e r_state;
    clint_state_e w_state_nxt;
    logic         r_req_ready;
    logic         r_rsp_valid;
    logic [63:0]  r_rsp_rdata;
    logic         r_rsp_err;
    logic [63:0]  r_mtimecmp;
    logic         r_mtip;
    logic [63:0]  w_mtime;
    logic         w_accept;
    logic         w_aligned;
    logic         w_hit_cmp;
    logic         w_hit_mtime;
    logic         w_hit_msip;
    logic         w_err;
    logic [63:0]  w_rd_data;
    logic         w_mtime_we;

    // Decode: a hit requires an exact, 8-byte aligned register address
    assign w_accept    = req_valid && (r_state == CLINT_FSM_IDLE);
    assign w_aligned   = (req_addr[2:0] == 3'b000);
    assign w_hit_cmp   = w_aligned && (req_addr == (BASE_ADDR + CLINT_MTIMECMP_OFS));
    assign w_hit_mtime = w_aligned && (req_addr == (BASE_ADDR + CLINT_MTIME_OFS));
`ifdef CLINT_MSIP_EN
    assign w_hit_msip  = w_aligned && (req_addr == (BASE_ADDR + CLINT_MSIP_OFS));
`else
    assign w_hit_msip  = 1'b0;
`endif
    assign w_err       = !(w_hit_cmp || w_hit_mtime || w_hit_msip);
    assign w_mtime_we  = w_accept && req_wen && w_hit_mtime;

    clint_mtime_cnt #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_mtime_we),
        .i_wr_data (merge_bytes(w_mtime, req_wdata, req_wstrb)),
        .o_mtime   (w_mtime)
    );

`ifdef CLINT_MSIP_EN
    logic r_msip;

    // msip: only bit0 is implemented and it needs byte lane 0 enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_msip <= 1'b0;
        end else if (w_accept && req_wen && w_hit_msip && req_wstrb[0]) begin
            r_msip <= req_wdata[0];
        end else begin
            r_msip <= r_msip;
        end
    end

    assign clint_msip = r_msip;
`endif

    // Read mux: pre-edge register values; writes and errors return zero
    always_comb begin
        w_rd_data = 64'd0;
        if (req_wen) begin
            w_rd_data = 64'd0;
        end else if (w_hit_cmp) begin
            w_rd_data = r_mtimecmp;
        end else if (w_hit_mtime) begin
            w_rd_data = w_mtime;
`ifdef CLINT_MSIP_EN
        end else if (w_hit_msip) begin
            w_rd_data = {63'd0, r_msip};
`endif
        end else begin
            w_rd_data = 64'd0;
        end
    end

    // mtimecmp register with byte-merged writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_accept && req_wen && w_hit_cmp) begin
            r_mtimecmp <= merge_bytes(r_mtimecmp, req_wdata, req_wstrb);
        end else begin
            r_mtimecmp <= r_mtimecmp;
        end
    end

    // Timer interrupt: compare of the pre-edge values, so updates show a cycle later
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (w_mtime >= r_mtimecmp);
        end
    end

    // FSM next state: IDLE accepts, RESP waits for the consumer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLINT_FSM_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = CLINT_FSM_RESP;
                end else begin
                    w_state_nxt = CLINT_FSM_IDLE;
                end
            end
            CLINT_FSM_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = CLINT_FSM_IDLE;
                end else begin
                    w_state_nxt = CLINT_FSM_RESP;
                end
            end
            default: begin
                w_state_nxt = CLINT_FSM_IDLE;
            end
        endcase
    end

    // FSM state plus registered handshake outputs and the latched response
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= CLINT_FSM_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == CLINT_FSM_IDLE);
            r_rsp_valid <= (w_state_nxt == CLINT_FSM_RESP);
            if (w_accept) begin
                r_rsp_rdata <= w_rd_data;
                r_rsp_err   <= w_err;
            end else begin
                r_rsp_rdata <= r_rsp_rdata;
                r_rsp_err   <= r_rsp_err;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign clint_mtip = r_mtip;

endmodule

// File: tb/tb_clint_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_clint_timer_unit
// Two instances (TICK_DIV=1 and TICK_DIV=3) receive identical bus traffic.
// A behavioural model keeps the architectural registers and a cycle count
// since reset; every negedge the outputs of both instances are compared.
// -----------------------------------------------------------------------------
module tb_clint_timer_unit;

    localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_CMP = BASE + 64'h4000;
    localparam logic [63:0] A_MT  = BASE + 64'hBFF8;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          TD0   = 1;
    localparam int          TD1   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wstrb = 8'd0;
    logic        rsp_ready = 1'b0;

    logic [1:0]  o_rdy;
    logic [1:0]  o_vld;
    logic [1:0]  o_err;
    logic [1:0]  o_mtip;
    logic [1:0]  o_msip;
    logic [63:0] o_rdata [2];

    always #5 clk = ~clk;

    clint_timer_unit #(.BASE_ADDR(BASE), .TICK_DIV(TD0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_rdy[0]),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(o_vld[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(o_rdata[0]), .rsp_err(o_err[0]), .clint_mtip(o_mtip[0])
`ifdef CLINT_MSIP_EN
        , .clint_msip(o_msip[0])
`endif
    );

    clint_timer_unit #(.BASE_ADDR(BASE), .TICK_DIV(TD1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_rdy[1]),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(o_vld[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(o_rdata[1]), .rsp_err(o_err[1]), .clint_mtip(o_mtip[1])
`ifdef CLINT_MSIP_EN
        , .clint_msip(o_msip[1])
`endif
    );

`ifndef CLINT_MSIP_EN
    assign o_msip = 2'b00;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [1:0]  m_mtip;
    logic        m_busy;
    logic [63:0] m_rdata [2];
    logic        m_err;
    logic        m_post_rst;
    longint      m_cyc;

    // 0 = unmapped, 1 = mtimecmp, 2 = mtime, 3 = msip
    function automatic int reg_of(input logic [63:0] a);
        if (a[2:0] != 3'b000) return 0;
        if (a == A_CMP) return 1;
        if (a == A_MT) return 2;
`ifdef CLINT_MSIP_EN
        if (a == BASE) return 3;
`endif
        return 0;
    endfunction

    function automatic logic [63:0] apply_strb(input logic [63:0] old_v, input logic [63:0] d,
                                               input logic [7:0] s);
        logic [63:0] mask;
        mask = 64'd0;
        for (int i = 0; i < 8; i++)
            if (s[i]) mask = mask | (64'hFF << (8 * i));
        return (old_v & ~mask) | (d & mask);
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] n_mtime [2];
        logic        acc;
        int          r;
        int          td;
        if (!rst) begin
            m_mtime[0] <= 64'd0;
            m_mtime[1] <= 64'd0;
            m_cmp      <= ONES;
            m_msip     <= 1'b0;
            m_mtip     <= 2'b00;
            m_busy     <= 1'b0;
            m_rdata[0] <= 64'd0;
            m_rdata[1] <= 64'd0;
            m_err      <= 1'b0;
            m_post_rst <= 1'b1;
            m_cyc      <= 0;
        end else begin
            acc = !m_busy && req_valid;
            r   = reg_of(req_addr);
            for (int k = 0; k < 2; k++) begin
                td = (k == 0) ? TD0 : TD1;
                m_mtip[k] <= (m_mtime[k] >= m_cmp);
                if (acc && req_wen && r == 2)
                    n_mtime[k] = apply_strb(m_mtime[k], req_wdata, req_wstrb);
                else if ((m_cyc % td) == td - 1)
                    n_mtime[k] = m_mtime[k] + 64'd1;
                else
                    n_mtime[k] = m_mtime[k];
                m_mtime[k] <= n_mtime[k];
                if (acc) begin
                    if (req_wen || r == 0) m_rdata[k] <= 64'd0;
                    else if (r == 1)       m_rdata[k] <= m_cmp;
                    else if (r == 2)       m_rdata[k] <= m_mtime[k];
                    else                   m_rdata[k] <= {63'd0, m_msip};
                end
            end
            if (acc) m_err <= (r == 0);
            if (acc && req_wen && r == 1) m_cmp <= apply_strb(m_cmp, req_wdata, req_wstrb);
            if (acc && req_wen && r == 3 && req_wstrb[0]) m_msip <= req_wdata[0];
            if (acc) m_busy <= 1'b1;
            else if (m_busy && rsp_ready) m_busy <= 1'b0;
            m_post_rst <= 1'b0;
            m_cyc      <= m_cyc + 1;
        end
    end

    // Compare both instances every cycle, away from the active edge
    always @(negedge clk) begin
        if ($time > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("req_ready[%0d]", k), {63'd0, o_rdy[k]}, {63'd0, !m_busy});
                chk($sformatf("rsp_valid[%0d]", k), {63'd0, o_vld[k]}, {63'd0, m_busy});
                chk($sformatf("mtip[%0d]", k), {63'd0, o_mtip[k]}, {63'd0, m_mtip[k]});
`ifdef CLINT_MSIP_EN
                chk($sformatf("msip[%0d]", k), {63'd0, o_msip[k]}, {63'd0, m_msip});
`endif
                if (m_busy || m_post_rst) begin
                    chk($sformatf("rdata[%0d]", k), o_rdata[k], m_rdata[k]);
                    chk($sformatf("err[%0d]", k), {63'd0, o_err[k]}, {63'd0, m_err});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One access; while the response is held, a junk write is offered that must be ignored
    task automatic access(input logic [63:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] s, input int hold);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b0;
        @(negedge clk);
        if (hold > 0) begin
            req_addr  = A_MT;
            req_wen   = 1'b1;
            req_wdata = {$urandom, $urandom};
            req_wstrb = 8'hFF;
            repeat (hold) @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        case ($urandom_range(0, 7))
            0: a = BASE;
            1, 2: a = A_CMP;
            3, 4: a = A_MT;
            5: a = BASE + 64'h1000;
            6: a = BASE + 64'h4004;
            default: a = A_MT + 64'($urandom_range(1, 7));
        endcase
        return a;
    endfunction

    function automatic logic [63:0] rnd_data();
        logic [63:0] d;
        case ($urandom_range(0, 3))
            0: d = {$urandom, $urandom};
            1: d = ONES - 64'($urandom_range(0, 4));
            default: d = 64'($urandom_range(0, 300));
        endcase
        return d;
    endfunction

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset value of mtimecmp
        access(A_CMP, 1'b0, 64'd0, 8'h00, 0);
        // mtip rises after mtime reaches mtimecmp, falls after mtimecmp is raised
        access(A_CMP, 1'b1, 64'd10, 8'hFF, 0);
        access(A_MT, 1'b1, 64'd0, 8'hFF, 0);
        repeat (40) @(negedge clk);
        access(A_CMP, 1'b1, 64'd1000, 8'hFF, 0);
        repeat (3) @(negedge clk);
        // partial byte write into mtime
        access(A_MT, 1'b1, 64'd0, 8'hFF, 0);
        access(A_MT, 1'b1, 64'hAAAA_BBBB_1234_5678, 8'h0F, 0);
        access(A_MT, 1'b0, 64'd0, 8'h00, 0);
        // wrap of mtime across mtimecmp
        access(A_CMP, 1'b1, 64'd5, 8'hFF, 0);
        access(A_MT, 1'b1, ONES, 8'hFF, 0);
        repeat (6) @(negedge clk);
        access(A_MT, 1'b0, 64'd0, 8'h00, 0);
        // response held with a competing request
        access(A_CMP, 1'b0, 64'd0, 8'h00, 3);
        // unmapped / misaligned / msip location, and a no-op write
        access(BASE + 64'h1000, 1'b0, 64'd0, 8'h00, 0);
        access(BASE + 64'h4004, 1'b1, ONES, 8'hFF, 0);
        access(BASE, 1'b1, 64'd1, 8'h01, 0);
        repeat (2) @(negedge clk);
        access(BASE, 1'b0, 64'd0, 8'h00, 0);
        access(A_CMP, 1'b1, ONES, 8'h00, 0);
        access(A_CMP, 1'b0, 64'd0, 8'h00, 0);
        // reset while a response is pending
        req_valid = 1'b1; req_addr = A_MT; req_wen = 1'b1; req_wdata = 64'd77; req_wstrb = 8'hFF;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(A_MT, 1'b0, 64'd0, 8'h00, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            access(rnd_addr(), 1'($urandom_range(0, 1)), rnd_data(),
                   8'($urandom_range(0, 255)), $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
